// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a byte FIFO (valid/ready in, serial txd out).
// Latency: byte accepted at edge N into an empty FIFO with the line idle drives the start bit from edge N+2.
// Backpressure: din_ready drops while the FIFO holds FIFO_DEPTH bytes; din_valid is ignored then.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset, released synchronously to clk
//   din         byte to transmit
//   din_valid   din is valid this cycle
//   din_ready   FIFO has room; transfer on (din_valid & din_ready) at a rising edge
//   txd         serial line, idle high, driven from a flop
//   busy        a frame is on the line or bytes are queued
//   tx_done     one-cycle pulse on the last cycle of each stop bit
//   fifo_count  number of queued bytes, 0..FIFO_DEPTH
module uart_tx_fifo #(
  parameter int CLK_FREQ     = 100000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
  parameter int FIFO_DEPTH   = 16,
  parameter int ADDR_W       = $clog2(FIFO_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              txd,
  output logic              busy,
  output logic              tx_done,
  output logic [ADDR_W:0]   fifo_count
);

  localparam int                BCNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [BCNT_W-1:0] BIT_LAST = BCNT_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W:0]   FULL     = (ADDR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state, state_nxt;
  logic [7:0]          mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
  logic [ADDR_W:0]     count, count_nxt;
  logic                avail;
  logic                push, pop, can_pop;
  logic [BCNT_W-1:0]   bcnt;
  logic                bit_end;
  logic [2:0]          idx;
  logic [7:0]          sh;

  // ---------------- FIFO ----------------
  assign din_ready  = (count != FULL);
  assign push       = din_valid & din_ready;
  assign fifo_count = count;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // avail is the FSM's view of "FIFO non-empty": it lags count by one edge,
  // so a freshly pushed byte is only seen on the following edge. It can read
  // stale-high right after a pop, but the FSM never looks at it then (it is
  // mid-frame), and can_pop also requires count != 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      avail  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      avail <= (count != '0);
    end
  end

  assign can_pop = avail && (count != '0);
  assign bit_end = (bcnt == BIT_LAST);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: if (can_pop) begin
        state_nxt = START;
        pop       = 1'b1;
      end
      START: if (bit_end) state_nxt = DATA;
      DATA:  if (bit_end && idx == 3'd7) state_nxt = STOP;
      STOP: if (bit_end) begin
        // Chain straight into the next start bit when a byte is waiting.
        if (can_pop) begin
          state_nxt = START;
          pop       = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    tx_done = 1'b0;
    if (state == STOP && bit_end) tx_done = 1'b1;
  end

  // ---------------- Datapath ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      txd  <= 1'b1;
      sh   <= '0;
      bcnt <= '0;
      idx  <= '0;
      busy <= 1'b0;
    end else begin
      // Built from next-state values so the flop matches the current state/count.
      busy <= (state_nxt != IDLE) || (count_nxt != '0);
      bcnt <= (state == IDLE || bit_end) ? '0 : bcnt + 1'b1;
      if (pop) begin
        sh  <= mem[rd_ptr];
        txd <= 1'b0;
      end else if (bit_end) begin
        case (state)
          START: begin
            txd <= sh[0];
            idx <= '0;
          end
          DATA: begin
            // sh[1] is the next bit because sh shifts on this same edge.
            sh  <= {1'b0, sh[7:1]};
            idx <= idx + 1'b1;
            txd <= (idx == 3'd7) ? 1'b1 : sh[1];
          end
          default: txd <= 1'b1;
        endcase
      end
    end
  end

endmodule
